// File: rtl/button_debouncer_pkg.sv
// Shared types and constants for the player-input debouncer: channel FSM states,
// button channel indices, default timing and the left/right cancel helper.
package button_debouncer_pkg;

    // Encoding keeps the stable level equal to state bit 1 (HELD and RELEASE_WAIT).
    typedef enum logic [1:0] {
        DB_IDLE         = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_HELD         = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam int CH_LEFT  = 0;
    localparam int CH_RIGHT = 1;
    localparam int CH_FIRE  = 2;
    localparam int CH_RESET = 3;
    localparam int NUM_BTN  = 4;

    localparam int DEF_DEBOUNCE_CYCLES    = 500000;
    localparam int DEF_CNT_W              = 19;
    localparam int DEF_FIRE_REPEAT_CYCLES = 12500000;

    // Returns {right, left}; holding both directions cancels both.
    function automatic logic [1:0] lr_cancel(input logic left_lvl, input logic right_lvl);
        return {right_lvl & ~left_lvl, left_lvl & ~right_lvl};
    endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// Raw board buttons in, debounced d_* game-control signals out.
// master = debouncer (producer of d_*), slave = board/game side.
interface button_debouncer_if;
    logic btn_left;
    logic btn_right;
    logic btn_fire;
    logic btn_reset;
    logic d_left;
    logic d_right;
    logic d_fire;
    logic d_reset;

    modport master (
        input  btn_left, btn_right, btn_fire, btn_reset,
        output d_left, d_right, d_fire, d_reset
    );

    modport slave (
        output btn_left, btn_right, btn_fire, btn_reset,
        input  d_left, d_right, d_fire, d_reset
    );
endinterface

// File: rtl/button_debouncer_channel.sv
// One button: 2-FF synchronizer feeding a stable-count debounce FSM.
// rise_o flags the edge on which a press is accepted; held_o is 1 in HELD only.
module button_debouncer_channel
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic stable_o,
    output logic rise_o,
    output logic held_o
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             sync_s;
    db_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-stage synchronizer for the asynchronous button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

    assign sync_s = sync_q[1];

    // Debounce FSM; the counter only runs in the *_WAIT states, so it never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DB_IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                DB_IDLE: begin
                    if (sync_s) begin
                        state_q <= DB_PRESS_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                DB_PRESS_WAIT: begin
                    if (!sync_s) begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DB_HELD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                DB_HELD: begin
                    if (!sync_s) begin
                        state_q <= DB_RELEASE_WAIT;
                        cnt_q   <= CNT_ONE;
                    end
                end
                DB_RELEASE_WAIT: begin
                    if (sync_s) begin
                        state_q <= DB_HELD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= DB_IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= DB_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign stable_o = state_q[1];
    assign held_o   = (state_q == DB_HELD);
    assign rise_o   = (state_q == DB_PRESS_WAIT) && sync_s && (cnt_q == CNT_LAST);

endmodule

// File: rtl/button_debouncer.sv
// Player-input front end: four debounced channels, left/right cancel and the fire pulse.
// Optional macro FIRE_AUTOREPEAT_EN adds a repeat counter that re-fires while fire is held.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES    = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W              = DEF_CNT_W,
    parameter int FIRE_REPEAT_CYCLES = DEF_FIRE_REPEAT_CYCLES
) (
    input  logic                clk,
    input  logic                rst,
    button_debouncer_if.master  bus
);
    logic [NUM_BTN-1:0] raw_s;
    logic [NUM_BTN-1:0] stable_s;
    logic [NUM_BTN-1:0] rise_s;
    logic [NUM_BTN-1:0] held_s;
    logic               fire_q;
    logic               unused_s;

    assign raw_s[CH_LEFT]  = bus.btn_left;
    assign raw_s[CH_RIGHT] = bus.btn_right;
    assign raw_s[CH_FIRE]  = bus.btn_fire;
    assign raw_s[CH_RESET] = bus.btn_reset;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        button_debouncer_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .btn_i    (raw_s[g]),
            .stable_o (stable_s[g]),
            .rise_o   (rise_s[g]),
            .held_o   (held_s[g])
        );
    end

`ifdef FIRE_AUTOREPEAT_EN
    localparam int               REP_W    = $clog2(FIRE_REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(FIRE_REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);

    logic [REP_W-1:0] rep_q;

    // Fire pulse on acceptance, then every FIRE_REPEAT_CYCLES in HELD; frozen in RELEASE_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_q <= 1'b0;
            rep_q  <= '0;
        end else begin
            fire_q <= rise_s[CH_FIRE];
            if (held_s[CH_FIRE]) begin
                if (rep_q == REP_LAST) begin
                    rep_q  <= '0;
                    fire_q <= 1'b1;
                end else begin
                    rep_q <= rep_q + REP_ONE;
                end
            end else if (!stable_s[CH_FIRE]) begin
                rep_q <= '0;
            end else begin
                rep_q <= rep_q;
            end
        end
    end

    assign unused_s = ^{rise_s[CH_LEFT], rise_s[CH_RIGHT], rise_s[CH_RESET],
                        held_s[CH_LEFT], held_s[CH_RIGHT], held_s[CH_RESET]};
`else
    localparam int unused_fire_repeat_cycles = FIRE_REPEAT_CYCLES;

    // One registered fire pulse per accepted press.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_q <= 1'b0;
        end else begin
            fire_q <= rise_s[CH_FIRE];
        end
    end

    assign unused_s = ^{rise_s[CH_LEFT], rise_s[CH_RIGHT], rise_s[CH_RESET], held_s};
`endif

    assign {bus.d_right, bus.d_left} = lr_cancel(stable_s[CH_LEFT], stable_s[CH_RIGHT]);
    assign bus.d_fire  = fire_q;
    assign bus.d_reset = stable_s[CH_RESET];

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer (DEBOUNCE_CYCLES=8, FIRE_REPEAT_CYCLES=20, CNT_W=5).
// Expected outputs are queued per edge and compared by a monitor #1 after each rising edge.
module tb_button_debouncer;
    localparam int DB  = 8;
    localparam int REP = 20;
    localparam int CW  = 5;
`ifdef FIRE_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    localparam logic [3:0] Z  = 4'b0000;
    localparam logic [3:0] L  = 4'b0001;
    localparam logic [3:0] R  = 4'b0010;
    localparam logic [3:0] F  = 4'b0100;
    localparam logic [3:0] RS = 4'b1000;

    typedef struct {
        logic [3:0] btn;
        int         len;
        logic [3:0] exp;
        string      name;
    } vec_t;

    typedef struct {
        int         tag;
        logic [3:0] exp;
        string      name;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    int   edge_n = 0;
    int   checks = 0;
    int   errors = 0;
    vec_t vecs[$];
    sb_t  sb[$];

    always #5 clk = ~clk;

    button_debouncer_if bus ();

    button_debouncer #(
        .DEBOUNCE_CYCLES    (DB),
        .CNT_W              (CW),
        .FIRE_REPEAT_CYCLES (REP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic set_btn(input logic [3:0] b);
        bus.btn_left  = b[0];
        bus.btn_right = b[1];
        bus.btn_fire  = b[2];
        bus.btn_reset = b[3];
    endtask

    task automatic expect_at(input int tag, input logic [3:0] e, input string n);
        sb_t item;
        item.tag  = tag;
        item.exp  = e;
        item.name = n;
        sb.push_back(item);
    endtask

    // Drive one segment from a negedge; expected value applies after its last edge.
    task automatic apply(input vec_t v);
        set_btn(v.btn);
        expect_at(edge_n + v.len, v.exp, v.name);
        repeat (v.len) @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [3:0] b, input int n, input logic [3:0] e, input string s);
        vec_t v;
        v.btn  = b;
        v.len  = n;
        v.exp  = e;
        v.name = s;
        return v;
    endfunction

    // Monitor: counts edges and checks every queued expectation due at this edge.
    initial begin : monitor
        sb_t        item;
        logic [3:0] got;
        forever begin
            @(posedge clk);
            #1;
            edge_n = edge_n + 1;
            got = {bus.d_reset, bus.d_fire, bus.d_right, bus.d_left};
            while (sb.size() > 0 && sb[0].tag <= edge_n) begin
                item   = sb.pop_front();
                checks = checks + 1;
                if (item.tag != edge_n || got !== item.exp) begin
                    errors = errors + 1;
                    $display("FAIL %s edge %0d (due %0d) got %b exp %b",
                             item.name, edge_n, item.tag, got, item.exp);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout at edge %0d", edge_n);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int  k;
        bit  pulse;

        // Test 1: left press/release latency
        vecs.push_back(mk(L, 9, Z, "t1_left_wait"));
        vecs.push_back(mk(L, 1, L, "t1_left_rise"));
        vecs.push_back(mk(L, 20, L, "t1_left_hold"));
        vecs.push_back(mk(Z, 9, L, "t1_rel_wait"));
        vecs.push_back(mk(Z, 1, Z, "t1_left_fall"));
        vecs.push_back(mk(Z, 5, Z, "t1_idle"));
        // Test 6: 7-cycle right glitch, then a genuine press with full latency
        vecs.push_back(mk(R, 7, Z, "t6_glitch"));
        vecs.push_back(mk(Z, 12, Z, "t6_after_glitch"));
        vecs.push_back(mk(R, 9, Z, "t6_press_wait"));
        vecs.push_back(mk(R, 1, R, "t6_right_rise"));
        vecs.push_back(mk(Z, 9, R, "t6_rel_wait"));
        vecs.push_back(mk(Z, 1, Z, "t6_right_fall"));
        // Test 3: left/right cancel
        vecs.push_back(mk(L, 9, Z, "t3_left_wait"));
        vecs.push_back(mk(L, 1, L, "t3_left_rise"));
        vecs.push_back(mk(L | R, 9, L, "t3_right_wait"));
        vecs.push_back(mk(L | R, 1, Z, "t3_cancel"));
        vecs.push_back(mk(L | R, 10, Z, "t3_both_held"));
        vecs.push_back(mk(L, 9, Z, "t3_right_rel_wait"));
        vecs.push_back(mk(L, 1, L, "t3_left_restored"));
        vecs.push_back(mk(Z, 9, L, "t3_left_rel_wait"));
        vecs.push_back(mk(Z, 1, Z, "t3_left_fall"));
        // Test 2: bouncing fire, then steady press; no pulse on release
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(F, 2, Z, "t2_bounce_hi"));
            vecs.push_back(mk(Z, 1, Z, "t2_bounce_lo"));
        end
        vecs.push_back(mk(F, 9, Z, "t2_fire_wait"));
        vecs.push_back(mk(F, 1, F, "t2_fire_pulse"));
        vecs.push_back(mk(F, 1, Z, "t2_pulse_end"));
        vecs.push_back(mk(F, 4, Z, "t2_fire_hold"));
        vecs.push_back(mk(Z, 10, Z, "t2_no_release_pulse"));
        // Simultaneous left and fire press
        vecs.push_back(mk(L | F, 9, Z, "sim_wait"));
        vecs.push_back(mk(L | F, 1, L | F, "sim_both"));
        vecs.push_back(mk(L | F, 1, L, "sim_fire_end"));
        vecs.push_back(mk(Z, 9, L, "sim_rel_wait"));
        vecs.push_back(mk(Z, 1, Z, "sim_fall"));
        // Test 5: fire held 100 cycles, per-cycle expectations
        for (int i = 1; i <= 100; i++) begin
            pulse = (i == 10) || (AR && i > 10 && ((i - 10) % REP) == 0);
            vecs.push_back(mk(F, 1, pulse ? F : Z, "t5_fire_hold"));
        end
        vecs.push_back(mk(Z, 9, Z, "t5_rel_wait"));
        vecs.push_back(mk(Z, 1, Z, "t5_released"));

        rst = 1'b1;
        set_btn(Z);
        @(negedge clk);
        expect_at(edge_n + 1, Z, "reset_state");
        expect_at(edge_n + 2, Z, "reset_state2");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        expect_at(edge_n + 1, Z, "first_cycle_after_rst");
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Test 4: reset mid-debounce, held button must re-debounce from scratch
        apply(mk(L, 9, Z, "t4_left_wait"));
        apply(mk(L, 1, L, "t4_left_rise"));
        apply(mk(L | RS, 6, L, "t4_reset_btn_count4"));
        rst = 1'b1;
        set_btn(RS);
        expect_at(edge_n + 1, Z, "t4_rst_clears");
        @(negedge clk);
        expect_at(edge_n + 1, Z, "t4_rst_hold");
        @(negedge clk);
        rst = 1'b0;
        apply(mk(RS, 9, Z, "t4_redebounce"));
        apply(mk(RS, 1, RS, "t4_d_reset_rise"));
        apply(mk(Z, 9, RS, "t4_rel_wait"));
        apply(mk(Z, 1, Z, "t4_d_reset_fall"));

        k = 0;
        while (sb.size() > 0 && k < 20) begin
            @(negedge clk);
            k = k + 1;
        end
        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL scoreboard_drain pending %0d required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
